// File: rtl/mdio_emul_pkg.sv
// Shared types and constants for the MDIO PHY register emulator.
package mdio_emul_pkg;

  // Frame tracking states
  typedef enum logic [2:0] {
    S_PRE,
    S_ST,
    S_OP,
    S_PHYAD,
    S_REGAD,
    S_TA,
    S_DATA,
    S_SKIP
  } state_t;

  // Clause-22 opcodes
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_WRITE = 2'b01;

  // Register addresses
  localparam logic [4:0] RA_CTRL    = 5'd0;
  localparam logic [4:0] RA_STAT    = 5'd1;
  localparam logic [4:0] RA_ID1     = 5'd2;
  localparam logic [4:0] RA_ID2     = 5'd3;
  localparam logic [4:0] RA_ANADV   = 5'd4;
  localparam logic [4:0] RA_ANLPA   = 5'd5;
  localparam logic [4:0] RA_PHYSTAT = 5'd17;

  // Register defaults / fixed values
  localparam logic [15:0] CTRL_DEF   = 16'h1140;
  localparam logic [15:0] STAT_DEF   = 16'h7949;
  localparam logic [15:0] ANADV_DEF  = 16'h01E1;
  localparam logic [15:0] ANLPA_LINK = 16'hC1E1;

endpackage

// File: rtl/mdio_bit_sync.sv
// Brings MDC/MDIO into the CLK domain and emits one strobe per MDC rising
// edge together with the MDIO value sampled alongside it.
module mdio_bit_sync
  import mdio_emul_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic mdc,
  input  logic mdio,
  output logic sample_stb,
  output logic sample_bit
);

  logic [2:0] mdc_q;
  logic [1:0] mdio_q;

  // Two-flop synchronizers, one extra MDC stage for edge detect; MDIO is
  // taken from the same synchronizer depth so it lines up with the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdc_q      <= '0;
      mdio_q     <= '0;
      sample_stb <= 1'b0;
      sample_bit <= 1'b0;
    end else begin
      mdc_q      <= {mdc_q[1:0], mdc};
      mdio_q     <= {mdio_q[0], mdio};
      sample_stb <= mdc_q[1] & ~mdc_q[2];
      sample_bit <= mdio_q[1];
    end
  end

endmodule

// File: rtl/mdio_phy_emul.sv
// Clause-22 MDIO target presenting a PHY register set derived from the
// PCS/PMA STATUS_VECTOR. Define MDIO_PRE_SUPPRESS_EN to accept frames
// after any single preamble one (preamble-suppressed masters).
module mdio_phy_emul
  import mdio_emul_pkg::*;
#(
  parameter logic [4:0]  PHY_ADDR = 5'd0,
  parameter int          PRE_LEN  = 32,
  parameter logic [15:0] PHY_ID1  = 16'h0141,
  parameter logic [15:0] PHY_ID2  = 16'h0CC2
) (
  input  logic        CLK,
  input  logic        SYS_RSTn,
  input  logic        MDC,
  input  logic        MDIO_IN,
  output logic        MDIO_OUT,
  output logic        MDIO_OE,
  input  logic [15:0] STATUS_VECTOR,
  output logic        REG_WR,
  output logic [4:0]  REG_ADDR,
  output logic [15:0] REG_WD,
  output logic [15:0] CTRL_REG
);

  localparam int            PW      = $clog2(PRE_LEN + 1);
  localparam logic [PW-1:0] PRE_SAT = PW'(PRE_LEN);
`ifdef MDIO_PRE_SUPPRESS_EN
  localparam logic [PW-1:0] PRE_MIN = PW'(1);
`else
  localparam logic [PW-1:0] PRE_MIN = PRE_SAT;
`endif

  logic          stb;
  logic          bin;
  state_t        state;
  logic [PW-1:0] pre_cnt;
  logic [3:0]    bit_cnt;
  logic          op_hi;
  logic          is_read;
  logic          foreign;
  logic [4:0]    regad;
  logic [15:0]   shreg;
  logic [15:0]   adv_reg;
  logic [4:0]    rd_addr;
  logic [15:0]   rd_val;
  logic [15:0]   wdata;
  logic          link;
  logic          drive;
  logic          unused_sv;

  assign unused_sv = ^{STATUS_VECTOR[14:13], STATUS_VECTOR[9:0]};

  mdio_bit_sync u_sync (
    .clk       (CLK),
    .rst_n     (SYS_RSTn),
    .mdc       (MDC),
    .mdio      (MDIO_IN),
    .sample_stb(stb),
    .sample_bit(bin)
  );

  // Address as it will be once the current REGAD bit is shifted in, so the
  // snapshot is taken on the edge that completes the address.
  assign rd_addr = {regad[3:0], bin};
  assign wdata   = {shreg[14:0], bin};
  assign link    = STATUS_VECTOR[15];
  assign drive   = is_read & ~foreign;

  // Register read map
  always_comb begin
    rd_val = '0;
    case (rd_addr)
      RA_CTRL:    rd_val = CTRL_REG;
      RA_STAT:    rd_val = STAT_DEF | {10'b0, link, 2'b0, link, 2'b0};
      RA_ID1:     rd_val = PHY_ID1;
      RA_ID2:     rd_val = PHY_ID2;
      RA_ANADV:   rd_val = adv_reg;
      RA_ANLPA:   rd_val = link ? ANLPA_LINK : 16'h0000;
      RA_PHYSTAT: rd_val = {STATUS_VECTOR[11:10], STATUS_VECTOR[12], 1'b1,
                            1'b0, link, 10'b0};
      default:    rd_val = '0;
    endcase
  end

  // Frame FSM: tracks every frame bit by bit, drives reads, commits writes
  always_ff @(posedge CLK or negedge SYS_RSTn) begin
    if (!SYS_RSTn) begin
      state    <= S_PRE;
      pre_cnt  <= '0;
      bit_cnt  <= '0;
      op_hi    <= 1'b0;
      is_read  <= 1'b0;
      foreign  <= 1'b0;
      regad    <= '0;
      shreg    <= '0;
      adv_reg  <= ANADV_DEF;
      MDIO_OUT <= 1'b0;
      MDIO_OE  <= 1'b0;
      REG_WR   <= 1'b0;
      REG_ADDR <= '0;
      REG_WD   <= '0;
      CTRL_REG <= CTRL_DEF;
    end else begin
      REG_WR <= 1'b0;
      if (stb) begin
        case (state)
          S_PRE: begin
            if (bin) begin
              if (pre_cnt != PRE_SAT) pre_cnt <= pre_cnt + PW'(1);
            end else begin
              // This zero is ST bit 0 when enough preamble was seen
              if (pre_cnt >= PRE_MIN) state <= S_ST;
              pre_cnt <= '0;
            end
          end
          S_ST: begin
            if (bin) begin
              state   <= S_OP;
              bit_cnt <= '0;
              foreign <= 1'b0;
            end else begin
              state   <= S_PRE;
              pre_cnt <= '0;
            end
          end
          S_OP: begin
            if (bit_cnt == 4'd0) begin
              op_hi   <= bin;
              bit_cnt <= 4'd1;
            end else begin
              bit_cnt <= '0;
              case ({op_hi, bin})
                OP_READ: begin
                  is_read <= 1'b1;
                  state   <= S_PHYAD;
                end
                OP_WRITE: begin
                  is_read <= 1'b0;
                  state   <= S_PHYAD;
                end
                default: state <= S_SKIP;
              endcase
            end
          end
          S_PHYAD: begin
            // PHY address is collected in regad, then checked as a whole
            regad <= rd_addr;
            if (bit_cnt == 4'd4) begin
              if (rd_addr != PHY_ADDR) foreign <= 1'b1;
              bit_cnt <= '0;
              state   <= S_REGAD;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
          S_REGAD: begin
            regad <= rd_addr;
            if (bit_cnt == 4'd4) begin
              shreg   <= rd_val;
              bit_cnt <= '0;
              state   <= S_TA;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
          S_TA: begin
            if (bit_cnt == 4'd0) begin
              bit_cnt <= 4'd1;
              if (drive) begin
                MDIO_OE  <= 1'b1;
                MDIO_OUT <= 1'b0;
              end
            end else begin
              bit_cnt <= '0;
              state   <= S_DATA;
              if (drive) begin
                MDIO_OUT <= shreg[15];
                shreg    <= {shreg[14:0], 1'b0};
              end
            end
          end
          S_DATA: begin
            if (is_read) begin
              if (drive) begin
                if (bit_cnt == 4'd15) begin
                  MDIO_OE  <= 1'b0;
                  MDIO_OUT <= 1'b0;
                end else begin
                  MDIO_OUT <= shreg[15];
                  shreg    <= {shreg[14:0], 1'b0};
                end
              end
            end else begin
              shreg <= wdata;
            end
            if (bit_cnt == 4'd15) begin
              state   <= S_PRE;
              pre_cnt <= '0;
              bit_cnt <= '0;
              if (!is_read && !foreign) begin
                REG_WR   <= 1'b1;
                REG_ADDR <= regad;
                REG_WD   <= wdata;
                if (regad == RA_CTRL)  CTRL_REG <= {1'b0, wdata[14:0]};
                if (regad == RA_ANADV) adv_reg  <= wdata;
              end
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
          S_SKIP: begin
            if (bit_cnt == 4'd15) begin
              state   <= S_PRE;
              pre_cnt <= '0;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
          default: begin
            state   <= S_PRE;
            pre_cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mdio_phy_emul.sv
// Scoreboard bench for mdio_phy_emul: a bit-banged MDIO master issues
// directed and random frames, pushes expected read words / write commits,
// and a monitor on the opposite CLK edge pops and compares.
module tb_mdio_phy_emul;

  localparam logic [4:0] MY_ADDR = 5'd0;
`ifdef MDIO_PRE_SUPPRESS_EN
  localparam int MIN_PRE = 1;
`else
  localparam int MIN_PRE = 32;
`endif

  logic        CLK = 1'b0;
  logic        SYS_RSTn = 1'b0;
  logic        MDC = 1'b0;
  logic        MDIO_IN = 1'b1;
  logic        MDIO_OUT;
  logic        MDIO_OE;
  logic [15:0] STATUS_VECTOR = 16'h0000;
  logic        REG_WR;
  logic [4:0]  REG_ADDR;
  logic [15:0] REG_WD;
  logic [15:0] CTRL_REG;

  mdio_phy_emul #(
    .PHY_ADDR(MY_ADDR),
    .PRE_LEN (32),
    .PHY_ID1 (16'h0141),
    .PHY_ID2 (16'h0CC2)
  ) dut (
    .CLK          (CLK),
    .SYS_RSTn     (SYS_RSTn),
    .MDC          (MDC),
    .MDIO_IN      (MDIO_IN),
    .MDIO_OUT     (MDIO_OUT),
    .MDIO_OE      (MDIO_OE),
    .STATUS_VECTOR(STATUS_VECTOR),
    .REG_WR       (REG_WR),
    .REG_ADDR     (REG_ADDR),
    .REG_WD       (REG_WD),
    .CTRL_REG     (CTRL_REG)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [4:0]  a;
    logic [15:0] d;
    logic [15:0] c;
  } wr_t;

  // Expectation queues: master pushes, monitor pops
  logic [15:0] rd_exp [0:255];
  wr_t         wr_exp [0:255];
  int          rd_push = 0;
  int          rd_pop  = 0;
  int          wr_push = 0;
  int          wr_pop  = 0;
  bit          done = 1'b0;

  // Reference register state
  logic [15:0] m_ctrl = 16'h1140;
  logic [15:0] m_adv  = 16'h01E1;

  int          n_cmp = 0;
  int          n_err = 0;
  logic        mdc_q = 1'b0;
  int          rd_n = 0;
  logic [16:0] rd_bits = '0;

  function automatic logic [15:0] model_read(input logic [4:0] a, input logic [15:0] sv,
                                             input logic [15:0] ctrl, input logic [15:0] adv);
    int link, dup, spd, v;
    link = int'(sv[15]);
    dup  = int'(sv[12]);
    spd  = int'(sv[11:10]);
    case (a)
      5'd0:    v = int'(ctrl);
      5'd1:    v = 'h7949 + link * 'h24;
      5'd2:    v = 'h0141;
      5'd3:    v = 'h0CC2;
      5'd4:    v = int'(adv);
      5'd5:    v = (link != 0) ? 'hC1E1 : 0;
      5'd17:   v = spd * 16384 + dup * 8192 + 4096 + link * 1024;
      default: v = 0;
    endcase
    return v[15:0];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // One MDC period: data changes while MDC is low, target samples on the rise
  task automatic send_bit(input logic b);
    MDIO_IN = b;
    repeat (5) @(posedge CLK);
    #2 MDC = 1'b1;
    repeat (5) @(posedge CLK);
    #2 MDC = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge CLK);
    #1 SYS_RSTn = 1'b0;
    repeat (2) @(posedge CLK);
    #1 SYS_RSTn = 1'b1;
    m_ctrl = 16'h1140;
    m_adv  = 16'h01E1;
  endtask

  // Full frame; pre is the number of preamble ones sent by this frame
  task automatic frame(input int pre, input logic [1:0] op, input logic [4:0] pa,
                       input logic [4:0] ra, input logic [15:0] wd,
                       input bit rst_mid, input bit sv_flip);
    bit ok;
    ok = (pre >= MIN_PRE) && (pa == MY_ADDR) && !rst_mid;
    if (ok && op == 2'b10) begin
      rd_exp[rd_push] = model_read(ra, STATUS_VECTOR, m_ctrl, m_adv);
      rd_push++;
    end else if (ok && op == 2'b01) begin
      if (ra == 5'd0) m_ctrl = wd & 16'h7FFF;
      if (ra == 5'd4) m_adv = wd;
      wr_exp[wr_push] = '{a: ra, d: wd, c: m_ctrl};
      wr_push++;
    end
    for (int i = 0; i < pre; i++) send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(op[1]);
    send_bit(op[0]);
    for (int i = 4; i >= 0; i--) send_bit(pa[i]);
    for (int i = 4; i >= 0; i--) send_bit(ra[i]);
    if (op == 2'b10) begin
      send_bit(1'b1);
      send_bit(1'b1);
      if (sv_flip) STATUS_VECTOR = 16'($urandom);
      for (int i = 15; i >= 0; i--) begin
        send_bit(1'b1);
        if (rst_mid && i == 8) pulse_reset();
      end
    end else begin
      send_bit(1'b1);
      send_bit(1'b0);
      for (int i = 15; i >= 0; i--) send_bit(wd[i]);
    end
    send_bit(1'b1);
    send_bit(1'b1);
  endtask

  // Stimulus
  initial begin
    bit          clean;
    int          pre, r;
    logic [1:0]  op;
    logic [4:0]  pa, ra;
    logic [15:0] wd;
    logic [4:0]  ra_tab [0:7];
    ra_tab[0] = 5'd0; ra_tab[1] = 5'd1; ra_tab[2] = 5'd2;  ra_tab[3] = 5'd3;
    ra_tab[4] = 5'd4; ra_tab[5] = 5'd5; ra_tab[6] = 5'd17; ra_tab[7] = 5'd9;

    repeat (4) @(posedge CLK);
    #1 SYS_RSTn = 1'b1;
    repeat (4) @(posedge CLK);

    STATUS_VECTOR = 16'h8800;
    frame(32, 2'b10, 5'd0, 5'd1, 16'h0, 0, 0);      // 796D
    STATUS_VECTOR = 16'h9800;
    frame(32, 2'b10, 5'd0, 5'd17, 16'h0, 0, 0);     // B400
    frame(32, 2'b01, 5'd0, 5'd0, 16'h9200, 0, 0);   // ctrl -> 1200
    frame(32, 2'b10, 5'd0, 5'd0, 16'h0, 0, 0);      // 1200
    frame(32, 2'b10, 5'd3, 5'd1, 16'h0, 0, 0);      // foreign: silent
    frame(20, 2'b10, 5'd0, 5'd1, 16'h0, 0, 0);      // short preamble
    frame(32, 2'b10, 5'd0, 5'd2, 16'h0, 0, 0);
    frame(32, 2'b01, 5'd0, 5'd4, 16'hABCD, 0, 0);
    frame(32, 2'b10, 5'd0, 5'd4, 16'h0, 0, 1);
    STATUS_VECTOR = 16'h8400;
    frame(32, 2'b10, 5'd0, 5'd5, 16'h0, 0, 0);
    frame(32, 2'b10, 5'd0, 5'd3, 16'h0, 1, 0);      // reset at data bit 8
    frame(32, 2'b10, 5'd0, 5'd0, 16'h0, 0, 0);      // back to 1140
    frame(32, 2'b10, 5'd0, 5'd4, 16'h0, 0, 0);      // back to 01E1
    frame(32, 2'b11, 5'd0, 5'd0, 16'hFFFF, 0, 0);   // invalid opcode
    frame(32, 2'b10, 5'd0, 5'd3, 16'h0, 0, 0);
    clean = 1'b1;

    for (int n = 0; n < 40; n++) begin
      // short preambles only right after a fully tracked frame so the
      // ones trailing the previous frame cannot reach the threshold
      if (clean && $urandom_range(0, 4) == 0) pre = 10;
      else pre = 32 + $urandom_range(0, 6);
      r = $urandom_range(0, 9);
      op = (r == 0) ? 2'b11 : (r < 5) ? 2'b10 : 2'b01;
      pa = ($urandom_range(0, 6) == 0) ? 5'($urandom_range(1, 31)) : MY_ADDR;
      ra = ra_tab[$urandom_range(0, 7)];
      wd = 16'($urandom);
      if (op == 2'b11) wd = wd | 16'h0FFF;
      if ($urandom_range(0, 2) == 0) STATUS_VECTOR = 16'($urandom);
      frame(pre, op, pa, ra, wd, 0, bit'($urandom_range(0, 1)));
      clean = (op != 2'b11) && (pre >= MIN_PRE);
    end
    repeat (20) @(posedge CLK);
    done = 1'b1;
  end

  // Monitor: samples on the falling CLK edge, away from DUT updates
  initial begin
    forever begin
      @(negedge CLK);
      if (!SYS_RSTn) begin
        rd_n    = 0;
        rd_bits = '0;
        chk("rst_mdio_oe", 32'(MDIO_OE), 32'h0);
        chk("rst_mdio_out", 32'(MDIO_OUT), 32'h0);
        chk("rst_reg_wr", 32'(REG_WR), 32'h0);
        chk("rst_reg_addr", 32'(REG_ADDR), 32'h0);
        chk("rst_reg_wd", 32'(REG_WD), 32'h0);
        chk("rst_ctrl_reg", 32'(CTRL_REG), 32'h1140);
      end else begin
        if (MDC && !mdc_q) begin
          if (MDIO_OE) begin
            rd_bits = {rd_bits[15:0], MDIO_OUT};
            rd_n++;
          end else if (rd_n != 0) begin
            if (rd_pop >= rd_push) begin
              n_cmp++;
              n_err++;
              $display("FAIL rd_unexpected: drove %0d bits (%0h), expected no drive", rd_n, rd_bits);
            end else begin
              chk("rd_len", 32'(rd_n), 32'd17);
              chk("rd_data", 32'(rd_bits), {15'h0, 1'b0, rd_exp[rd_pop]});
              rd_pop++;
            end
            rd_n    = 0;
            rd_bits = '0;
          end
        end
        if (REG_WR) begin
          if (wr_pop >= wr_push) begin
            n_cmp++;
            n_err++;
            $display("FAIL wr_unexpected: REG_ADDR %0h REG_WD %0h, expected no write", REG_ADDR, REG_WD);
          end else begin
            chk("wr_addr", 32'(REG_ADDR), 32'(wr_exp[wr_pop].a));
            chk("wr_data", 32'(REG_WD), 32'(wr_exp[wr_pop].d));
            chk("wr_ctrl_reg", 32'(CTRL_REG), 32'(wr_exp[wr_pop].c));
            wr_pop++;
          end
        end
      end
      mdc_q = MDC;
      if (done) begin
        chk("rd_outstanding", 32'(rd_push - rd_pop), 32'h0);
        chk("wr_outstanding", 32'(wr_push - wr_pop), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
      end
    end
  end

endmodule
